// File: rtl/id_scoreboard_pkg.sv
// Shared scoreboard definitions: default widths and the latency encodings used
// by decode when it issues an instruction.
package id_scoreboard_pkg;

    localparam int SB_REG_ADDR_W = 5;
    localparam int SB_LAT_W      = 3;
    localparam int SB_LAT_INF    = (1 << SB_LAT_W) - 1;

    // Latency classes decode attaches to each register-writing instruction.
    typedef enum logic [SB_LAT_W-1:0] {
        LAT_ALU  = SB_LAT_W'(0),
        LAT_LOAD = SB_LAT_W'(1),
        LAT_MUL  = SB_LAT_W'(2),
        LAT_DIV  = SB_LAT_W'(SB_LAT_INF)
    } lat_class_e;

endpackage

// File: rtl/sb_entry.sv
// One scoreboard entry: counts down the cycles until a pending write becomes
// forwardable. The all-ones count is a sticky busy marker that only a clear
// or a flush releases.
module sb_entry
    import id_scoreboard_pkg::*;
#(
    parameter int LAT_W = SB_LAT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             issue,
    input  logic [LAT_W-1:0] lat,
    input  logic             clear,
    output logic             busy
);

    localparam logic [LAT_W-1:0] LAT_INF = '1;

    logic [LAT_W-1:0] cnt;

    // NOTE: state uses non-blocking assignments so every entry samples the
    // pre-edge inputs; the counters reset asynchronously so a mid-run reset
    // drops all stalls before the next edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (flush) begin
            cnt <= '0;
        end else if (issue) begin
            cnt <= lat;
        end else if (clear) begin
            cnt <= '0;
        end else if (cnt != '0 && cnt != LAT_INF) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign busy = (cnt != '0);

endmodule

// File: rtl/id_scoreboard.sv
// Per-register pending-write scoreboard beside the decode stage. The busy
// outputs depend only on stored counts, so the stall -> issue_fire path never
// loops back into them.
module id_scoreboard
    import id_scoreboard_pkg::*;
#(
    parameter int REG_ADDR_W = SB_REG_ADDR_W,
    parameter int LAT_W      = SB_LAT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid_i,
    input  logic                  issue_wreg_i,
    input  logic [REG_ADDR_W-1:0] issue_wd_i,
    input  logic [LAT_W-1:0]      issue_lat_i,
    input  logic                  clear_valid_i,
    input  logic [REG_ADDR_W-1:0] clear_addr_i,
    input  logic                  flush_i,
    input  logic                  reg1_read_i,
    input  logic [REG_ADDR_W-1:0] reg1_addr_i,
    input  logic                  reg2_read_i,
    input  logic [REG_ADDR_W-1:0] reg2_addr_i,
    output logic                  reg1_busy_o,
    output logic                  reg2_busy_o,
    output logic                  stallreq_o,
    output logic                  issue_fire_o
);

    localparam int NUM_REGS = 2 ** REG_ADDR_W;

    logic [NUM_REGS-1:0] busy;
    logic                issue_write;

    // Register 0 is hardwired zero and never needs a stall.
    assign busy[0] = 1'b0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
        sb_entry #(
            .LAT_W(LAT_W)
        ) u_entry (
            .clk  (clk),
            .rst  (rst),
            .flush(flush_i),
            .issue(issue_write && (issue_wd_i == REG_ADDR_W'(r))),
            .lat  (issue_lat_i),
            .clear(clear_valid_i && (clear_addr_i == REG_ADDR_W'(r))),
            .busy (busy[r])
        );
    end

    assign reg1_busy_o  = reg1_read_i && busy[reg1_addr_i];
    assign reg2_busy_o  = reg2_read_i && busy[reg2_addr_i];
    assign stallreq_o   = reg1_busy_o || reg2_busy_o;
    assign issue_fire_o = issue_valid_i && !stallreq_o && !flush_i;
    assign issue_write  = issue_fire_o && issue_wreg_i;

endmodule

// File: tb/tb_id_scoreboard.sv
// Self-checking bench for id_scoreboard: a "free from cycle N" model per
// register, checked every cycle, plus directed scenarios with literal values.
module tb_id_scoreboard;
    import id_scoreboard_pkg::*;

    localparam int AW   = 5;
    localparam int LW   = 3;
    localparam int NREG = 32;
    localparam int NEVER = 32'h7fff_ffff;

    logic          clk = 1'b0;
    logic          rst;
    logic          issue_valid_i, issue_wreg_i;
    logic [AW-1:0] issue_wd_i;
    logic [LW-1:0] issue_lat_i;
    logic          clear_valid_i;
    logic [AW-1:0] clear_addr_i;
    logic          flush_i;
    logic          reg1_read_i, reg2_read_i;
    logic [AW-1:0] reg1_addr_i, reg2_addr_i;
    logic          reg1_busy_o, reg2_busy_o, stallreq_o, issue_fire_o;

    int tests  = 0;
    int errors = 0;
    bit check_en = 1'b0;

    // Model: register r is busy in cycle c exactly when c < free_at[r].
    int cyc = 0;
    int free_at[NREG];

    id_scoreboard #(.REG_ADDR_W(AW), .LAT_W(LW)) dut (
        .clk          (clk),
        .rst          (rst),
        .issue_valid_i(issue_valid_i),
        .issue_wreg_i (issue_wreg_i),
        .issue_wd_i   (issue_wd_i),
        .issue_lat_i  (issue_lat_i),
        .clear_valid_i(clear_valid_i),
        .clear_addr_i (clear_addr_i),
        .flush_i      (flush_i),
        .reg1_read_i  (reg1_read_i),
        .reg1_addr_i  (reg1_addr_i),
        .reg2_read_i  (reg2_read_i),
        .reg2_addr_i  (reg2_addr_i),
        .reg1_busy_o  (reg1_busy_o),
        .reg2_busy_o  (reg2_busy_o),
        .stallreq_o   (stallreq_o),
        .issue_fire_o (issue_fire_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic exp_busy(input logic rd, input logic [AW-1:0] a);
        return rd && (a != 0) && (cyc < free_at[a]);
    endfunction

    function automatic logic exp_stall();
        return exp_busy(reg1_read_i, reg1_addr_i) || exp_busy(reg2_read_i, reg2_addr_i);
    endfunction

    function automatic logic exp_fire();
        return issue_valid_i && !exp_stall() && !flush_i;
    endfunction

    // Model update from the rules: flush frees everything next cycle, a clear
    // frees next cycle, an accepted write is busy for exactly L cycles.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) free_at[r] <= 0;
        end else begin
            if (flush_i) begin
                for (int r = 0; r < NREG; r++) free_at[r] <= cyc + 1;
            end else begin
                if (clear_valid_i) free_at[clear_addr_i] <= cyc + 1;
                if (exp_fire() && issue_wreg_i && issue_wd_i != 0)
                    free_at[issue_wd_i] <= (int'(issue_lat_i) == SB_LAT_INF) ? NEVER
                                                                              : cyc + 1 + int'(issue_lat_i);
            end
            cyc <= cyc + 1;
        end
    end

    always @(negedge clk) begin
        if (check_en && !rst) begin
            check("model_reg1_busy", reg1_busy_o, exp_busy(reg1_read_i, reg1_addr_i));
            check("model_reg2_busy", reg2_busy_o, exp_busy(reg2_read_i, reg2_addr_i));
            check("model_stallreq", stallreq_o, exp_stall());
            check("model_issue_fire", issue_fire_o, exp_fire());
        end
    end

    task automatic idle();
        issue_valid_i = 0; issue_wreg_i = 0; issue_wd_i = '0; issue_lat_i = '0;
        clear_valid_i = 0; clear_addr_i = '0; flush_i = 0;
        reg1_read_i = 0; reg1_addr_i = '0; reg2_read_i = 0; reg2_addr_i = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [AW-1:0] wd, input logic [LW-1:0] lat);
        issue_valid_i = 1; issue_wreg_i = 1; issue_wd_i = wd; issue_lat_i = lat;
    endtask

    task automatic read_both(input logic [AW-1:0] a);
        reg1_read_i = 1; reg1_addr_i = a; reg2_read_i = 1; reg2_addr_i = a;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        repeat (3) tick();
        rst = 1'b0;
        check_en = 1'b1;

        // Load-use: L=1 gives exactly one stall cycle.
        reg1_read_i = 1; reg1_addr_i = 5'd5;
        issue(5'd5, LW'(LAT_LOAD));
        #2 check("reset_no_stall", stallreq_o, 1'b0);
        check("reset_fire_follows_valid", issue_fire_o, 1'b1);
        tick();
        idle(); reg1_read_i = 1; reg1_addr_i = 5'd5;
        #2 check("load_use_stall", stallreq_o, 1'b1);
        tick();
        #2 check("load_use_released", stallreq_o, 1'b0);

        // L=3 on both ports, then only port 1 reading.
        idle(); issue(5'd8, 3'd3);
        tick();
        idle(); read_both(5'd8);
        for (int i = 0; i < 3; i++) begin
            #2 check("r8_stall", stallreq_o, 1'b1);
            tick();
        end
        #2 check("r8_free", stallreq_o, 1'b0);
        idle(); issue(5'd8, 3'd3);
        tick();
        idle(); reg1_read_i = 1; reg1_addr_i = 5'd8; reg2_addr_i = 5'd8;
        #2 check("r8_reg1_busy", reg1_busy_o, 1'b1);
        check("r8_reg2_unread", reg2_busy_o, 1'b0);
        repeat (3) tick();

        // Busy-until-cleared entry, and a clear of an idle register.
        idle(); issue(5'd3, LW'(LAT_DIV));
        tick();
        idle(); reg1_read_i = 1; reg1_addr_i = 5'd3;
        repeat (10) tick();
        #2 check("r3_inf_held", reg1_busy_o, 1'b1);
        clear_valid_i = 1; clear_addr_i = 5'd3;
        tick();
        clear_valid_i = 0;
        #2 check("r3_cleared", reg1_busy_o, 1'b0);
        reg2_read_i = 1; reg2_addr_i = 5'd4; clear_valid_i = 1; clear_addr_i = 5'd4;
        tick();
        clear_valid_i = 0;
        #2 check("r4_idle_clear", reg2_busy_o, 1'b0);

        // r0 is never busy; issue overrides a same-cycle clear.
        idle(); issue(5'd0, 3'd2);
        tick();
        idle(); read_both(5'd0);
        #2 check("r0_never_busy", stallreq_o, 1'b0);
        idle(); issue(5'd9, 3'd4); clear_valid_i = 1; clear_addr_i = 5'd9;
        tick();
        idle(); reg1_read_i = 1; reg1_addr_i = 5'd9;
        for (int i = 0; i < 4; i++) begin
            #2 check("r9_issue_beats_clear", reg1_busy_o, 1'b1);
            tick();
        end
        #2 check("r9_free", reg1_busy_o, 1'b0);

        // Flush wipes every entry and drops the issue in the flush cycle.
        idle(); issue(5'd6, LW'(LAT_DIV));
        tick();
        idle(); issue(5'd7, LW'(LAT_MUL));
        tick();
        idle(); issue(5'd10, 3'd3); flush_i = 1;
        #2 check("flush_fire_blocked", issue_fire_o, 1'b0);
        tick();
        idle(); reg1_read_i = 1; reg1_addr_i = 5'd6; reg2_read_i = 1; reg2_addr_i = 5'd7;
        #2 check("flush_r6_r7_free", stallreq_o, 1'b0);
        reg1_addr_i = 5'd10;
        #1 check("flush_r10_dropped", reg1_busy_o, 1'b0);
        tick();

        // A stalled issue is not recorded; async reset drops busy immediately.
        idle(); issue(5'd2, 3'd6);
        tick();
        idle(); issue(5'd11, 3'd5); reg1_read_i = 1; reg1_addr_i = 5'd2;
        #2 check("stalled_issue_fire", issue_fire_o, 1'b0);
        tick();
        idle(); reg1_read_i = 1; reg1_addr_i = 5'd11; reg2_read_i = 1; reg2_addr_i = 5'd2;
        #2 check("stalled_issue_unrecorded", reg1_busy_o, 1'b0);
        check("r2_still_busy", reg2_busy_o, 1'b1);
        rst = 1'b1;
        #1 check("async_reset_busy", reg2_busy_o, 1'b0);
        tick();
        rst = 1'b0;

        // Random traffic over a small register window to force collisions.
        for (int n = 0; n < 3000; n++) begin
            idle();
            issue_valid_i = ($urandom_range(0, 1) == 1);
            issue_wreg_i  = ($urandom_range(0, 3) != 0);
            issue_wd_i    = AW'($urandom_range(0, 12));
            issue_lat_i   = ($urandom_range(0, 7) == 0) ? LW'(LAT_DIV) : LW'($urandom_range(0, 6));
            clear_valid_i = ($urandom_range(0, 4) == 0);
            clear_addr_i  = AW'($urandom_range(0, 12));
            flush_i       = ($urandom_range(0, 40) == 0);
            reg1_read_i   = ($urandom_range(0, 3) != 0);
            reg1_addr_i   = AW'($urandom_range(0, 12));
            reg2_read_i   = ($urandom_range(0, 1) == 1);
            reg2_addr_i   = AW'($urandom_range(0, 12));
            tick();
        end

        idle();
        tick();
        check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/id_scoreboard.md
# id_scoreboard

Parametrised register scoreboard for the decode stage, generalising the fixed EX/MEM forwarding and single load-use stall into a per-register pending-write tracker. Each issued instruction that writes a register records how many cycles remain until its result is forwardable. Variable-latency results (HI/LO divide, cache-miss loads) are held busy until explicitly cleared. The block sits beside the decode stage, drives the decode stall request, and is cleared by the exception/flush path.

## Interface
- REG_ADDR_W, 5, register address width; NUM_REGS = 2**REG_ADDR_W
- LAT_W, 3, latency field width; LAT_INF = 2**LAT_W-1 means "busy until cleared"
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-high reset
- issue_valid_i  in  1  decode stage hands an instruction to EX this cycle
- issue_wreg_i  in  1  issued instruction writes a register
- issue_wd_i  in  REG_ADDR_W  destination register
- issue_lat_i  in  LAT_W  cycles until the result is forwardable (0..LAT_INF-1), or LAT_INF
- clear_valid_i  in  1  variable-latency unit delivered its result
- clear_addr_i  in  REG_ADDR_W  register being released
- flush_i  in  1  exception/pipeline flush
- reg1_read_i / reg2_read_i  in  1  decode reads source 1 / 2
- reg1_addr_i / reg2_addr_i  in  REG_ADDR_W  source addresses
- reg1_busy_o / reg2_busy_o  out  1  source has a pending, non-forwardable write
- stallreq_o  out  1  decode must hold
- issue_fire_o  out  1  issue accepted this cycle

## Operation
- State: one LAT_W-bit counter cnt[r] per register. busy[r] = (cnt[r] != 0). Register 0 is never busy and its counter is never written.
- regN_busy_o = regN_read_i & busy[regN_addr_i]. stallreq_o = reg1_busy_o | reg2_busy_o. All three outputs are combinational from state and current inputs.
- issue_fire_o = issue_valid_i & ~stallreq_o & ~flush_i. A stalled issue leaves no record.
- Per-cycle update for each r, highest priority first:
  1. flush_i: cnt[r] <= 0 (all registers, including LAT_INF entries).
  2. issue_fire_o & issue_wreg_i & issue_wd_i==r & r!=0: cnt[r] <= issue_lat_i.
  3. clear_valid_i & clear_addr_i==r: cnt[r] <= 0.
  4. cnt[r] not in {0, LAT_INF}: cnt[r] <= cnt[r]-1.
  5. Otherwise hold.
- Issue overrides clear and decrement on the same register. A WAW re-issue replaces the old count, even if it is smaller.
- Clearing a register that is not busy has no effect. A clear for a register that has been re-issued with a finite latency is lost by design: the unit must not clear a register it no longer owns.
- Decrement saturates at 0. LAT_INF never decrements.

## Timing
- Reset: all cnt = 0, so reg1_busy_o, reg2_busy_o and stallreq_o are 0. issue_fire_o follows issue_valid_i.
- An issue at edge t with latency L makes the register busy in cycles t+1 .. t+L and free in cycle t+L+1.
- L = 0: never busy, because EX forwarding covers it. L = 1: one stall cycle, which is the load-use case.
- A clear at edge t makes the register free in cycle t+1.
- A flush at edge t makes all registers free in cycle t+1. Any issue in the flush cycle is dropped.
- Reset asserted mid-operation clears all counters immediately (asynchronous).
- No combinational path runs from issue_* or clear_* to busy outputs except through stallreq_o → issue_fire_o. That path must not loop back into the busy outputs.

## Structure
- The shared defines header gains LAT_W, LAT_INF and the latency encodings used by decode: LAT_ALU=0, LAT_LOAD=1, LAT_MUL=2, LAT_DIV=LAT_INF.
- One natural sub-module, sb_entry: a single counter with issue/clear/flush priority and a busy output, instantiated NUM_REGS-1 times by generate. Entry 0 is tied off.

## Test plan
- Reset, then read r5 with reg1_read_i=1 → stallreq_o=0. Issue r5 with L=1, then read r5 in the next cycle → stallreq_o=1 for exactly 1 cycle, 0 in the cycle after.
- Issue r8 with L=3; read r8 on both ports each cycle → stallreq_o high for 3 cycles. With reg2_read_i=0, only reg1_busy_o is asserted.
- Issue r3 with L=LAT_INF; hold 10 cycles → r3 stays busy. Pulse clear_addr_i=3 → free in the next cycle. Clear r4 while idle → no change.
- Issue r0 with L=2 → r0 never busy. Issue r9 with L=4 and clear r9 in the same cycle → r9 busy for 4 cycles.
- With r6 at LAT_INF and r7 at 2, assert flush_i together with issue_valid_i to r10 → all registers free next cycle, issue_fire_o=0, and r10 is not busy.
- Make r2 busy, then present issue_valid_i with reg1_addr_i=2 → issue_fire_o=0 and the destination is not recorded. Assert rst mid-count → busy drops immediately.
